// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - reorder buffer kind encoding and per-entry control struct
package rob_pkg;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_JUMP   = 2'd3
    } kind_e;

    // Control half of an entry; wide pc/value/target live in plain arrays in the top.
    typedef struct packed {
        kind_e      kind;
        logic [4:0] rd;
        logic       done;
        logic       redirect;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - alloc/writeback/commit/flush bundle of the reorder buffer
interface reorder_buffer_if
    import rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
);
    localparam int TAG_W = $clog2(DEPTH);

    logic              alloc_valid;
    logic              alloc_ready;
    kind_e             alloc_kind;
    logic [4:0]        alloc_rd;
    logic [DATA_W-1:0] alloc_pc;
    logic [TAG_W-1:0]  alloc_tag;

    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_value;
    logic              wb_redirect;
    logic [DATA_W-1:0] wb_target;

    logic              cm_valid;
    logic              cm_ready;
    kind_e             cm_kind;
    logic [4:0]        cm_rd;
    logic [DATA_W-1:0] cm_value;
    logic [TAG_W-1:0]  cm_tag;

    logic              flush;
    logic [DATA_W-1:0] flush_pc;
    logic [TAG_W:0]    count;

    modport slave (
        input  alloc_valid, alloc_kind, alloc_rd, alloc_pc,
        output alloc_ready, alloc_tag,
        input  wb_valid, wb_tag, wb_value, wb_redirect, wb_target,
        output cm_valid, cm_kind, cm_rd, cm_value, cm_tag,
        input  cm_ready,
        output flush, flush_pc, count
    );

    modport master (
        output alloc_valid, alloc_kind, alloc_rd, alloc_pc,
        input  alloc_ready, alloc_tag,
        output wb_valid, wb_tag, wb_value, wb_redirect, wb_target,
        input  cm_valid, cm_kind, cm_rd, cm_value, cm_tag,
        output cm_ready,
        input  flush, flush_pc, count
    );

endinterface

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - head/tail pointers with wrap bits, full/empty and occupancy
module rob_ptr_ctrl #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [TAG_W-1:0] head_idx_o,
    output logic [TAG_W-1:0] tail_idx_o,
    output logic [TAG_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    logic [TAG_W:0] head_q, head_d;
    logic [TAG_W:0] tail_q, tail_d;

    // A redirect commit keeps only the committing entry's slot: tail lands just past it.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop_i)
            head_d = head_q + PTR_ONE;
        if (flush_i)
            tail_d = head_q + PTR_ONE;
        else if (push_i)
            tail_d = tail_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_idx_o = head_q[TAG_W-1:0];
    assign tail_idx_o = tail_q[TAG_W-1:0];
    assign count_o    = tail_q - head_q;
    assign empty_o    = (head_q == tail_q);
    assign full_o     = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) && (head_q[TAG_W] != tail_q[TAG_W]);

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer with redirect flush
// Optional ROB_WB_BYPASS_EN: writeback to an un-done head entry can commit in the same cycle.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    reorder_buffer_if.slave   rob
);
    localparam int TAG_W = $clog2(DEPTH);

    rob_entry_t        ctl_q    [DEPTH];
    logic [DATA_W-1:0] pc_q     [DEPTH];
    logic [DATA_W-1:0] value_q  [DEPTH];
    logic [DATA_W-1:0] target_q [DEPTH];

    logic              flush_q;
    logic [DATA_W-1:0] flush_pc_q;

    logic [TAG_W-1:0]  head_idx, tail_idx, wb_off;
    logic [TAG_W:0]    count;
    logic              full, empty;
    logic              push, commit, flush_trig, wb_ok, head_ready;
    logic              cm_redirect;
    logic [DATA_W-1:0] cm_target;

    rob_ptr_ctrl #(.TAG_W(TAG_W)) u_ptr (
        .clk        (clk),
        .clr        (clr),
        .push_i     (push),
        .pop_i      (commit),
        .flush_i    (flush_trig),
        .head_idx_o (head_idx),
        .tail_idx_o (tail_idx),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Live window is [head, tail): offset from head must be below occupancy.
    assign wb_off = rob.wb_tag - head_idx;
    assign wb_ok  = rob.wb_valid && ({1'b0, wb_off} < count) && !ctl_q[rob.wb_tag].done;

`ifdef ROB_WB_BYPASS_EN
    logic byp;
    assign byp          = wb_ok && (rob.wb_tag == head_idx);
    assign head_ready   = ctl_q[head_idx].done || byp;
    assign rob.cm_value = byp ? rob.wb_value    : value_q[head_idx];
    assign cm_redirect  = byp ? rob.wb_redirect : ctl_q[head_idx].redirect;
    assign cm_target    = byp ? rob.wb_target   : target_q[head_idx];
`else
    assign head_ready   = ctl_q[head_idx].done;
    assign rob.cm_value = value_q[head_idx];
    assign cm_redirect  = ctl_q[head_idx].redirect;
    assign cm_target    = target_q[head_idx];
`endif

    assign rob.alloc_ready = !clr && !full && !flush_q;
    assign rob.alloc_tag   = tail_idx;
    assign rob.cm_valid    = !empty && head_ready && !flush_q;
    assign rob.cm_kind     = ctl_q[head_idx].kind;
    assign rob.cm_rd       = ctl_q[head_idx].rd;
    assign rob.cm_tag      = head_idx;
    assign rob.flush       = flush_q;
    assign rob.flush_pc    = flush_pc_q;
    assign rob.count       = count;

    assign commit     = rob.cm_valid && rob.cm_ready;
    assign flush_trig = commit && cm_redirect;
    assign push       = rob.alloc_valid && rob.alloc_ready && !flush_trig;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++)
                ctl_q[i] <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            flush_q <= flush_trig;
            if (flush_trig) begin
                flush_pc_q <= cm_target;
                for (int i = 0; i < DEPTH; i++) begin
                    ctl_q[i].done     <= 1'b0;
                    ctl_q[i].redirect <= 1'b0;
                end
            end else begin
                if (push)
                    ctl_q[tail_idx] <= '{kind: rob.alloc_kind, rd: rob.alloc_rd, done: 1'b0, redirect: 1'b0};
                if (wb_ok) begin
                    ctl_q[rob.wb_tag].done     <= 1'b1;
                    ctl_q[rob.wb_tag].redirect <= rob.wb_redirect;
                end
            end
        end
    end

    // Payload needs no reset: it is only observed once the matching done bit is set.
    always_ff @(posedge clk) begin
        if (push)
            pc_q[tail_idx] <= rob.alloc_pc;
        if (wb_ok && !flush_trig) begin
            value_q[rob.wb_tag]  <= rob.wb_value;
            target_q[rob.wb_tag] <= rob.wb_target;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer at DEPTH=4
module tb_reorder_buffer;
    import rob_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

`ifdef ROB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk;
    logic clr;
    int   checks;
    int   errs;

    reorder_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .clr (clr),
        .rob (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input int tag, input logic [31:0] val, input logic redir, input logic [31:0] tgt);
        bus.wb_valid    = 1'b1;
        bus.wb_tag      = tag[1:0];
        bus.wb_value    = val;
        bus.wb_redirect = redir;
        bus.wb_target   = tgt;
    endtask

    initial begin
        logic [31:0] exp_v [3];
        checks = 0;
        errs   = 0;
        clr = 1'b1;
        bus.alloc_valid = 1'b0; bus.alloc_kind = KIND_REG; bus.alloc_rd = '0; bus.alloc_pc = '0;
        bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_value = '0; bus.wb_redirect = 1'b0; bus.wb_target = '0;
        bus.cm_ready = 1'b0;

        tick(); tick();
        chk("rst_alloc_ready", bus.alloc_ready, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_cm_valid", bus.cm_valid, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_flush_pc", bus.flush_pc, 0);
        clr = 1'b0;
        #1 chk("post_rst_alloc_ready", bus.alloc_ready, 1);

        // fill to full, then one commit frees a slot with tail wrapped
        for (int i = 0; i < 4; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_kind = KIND_REG; bus.alloc_rd = 5'(i + 1); bus.alloc_pc = 32'h100 + 32'(i);
            #1 chk("fill_tag", bus.alloc_tag, 64'(i));
            tick();
        end
        #1;
        chk("full_alloc_ready", bus.alloc_ready, 0);
        chk("full_count", bus.count, 4);
        tick();
        bus.alloc_valid = 1'b0;
        #1 chk("full_count_hold", bus.count, 4);
        wb(0, 32'hA0, 1'b0, 0);
        tick();
        bus.wb_valid = 1'b0; bus.cm_ready = 1'b1;
        #1;
        chk("full_cm_valid", bus.cm_valid, 1);
        chk("full_cm_value", bus.cm_value, 32'hA0);
        chk("full_cm_tag", bus.cm_tag, 0);
        tick();
        bus.cm_ready = 1'b0;
        #1;
        chk("after_commit_ready", bus.alloc_ready, 1);
        chk("after_commit_count", bus.count, 3);
        chk("wrap_alloc_tag", bus.alloc_tag, 0);

        // simultaneous alloc and commit
        wb(1, 32'hB1, 1'b0, 0);
        tick();
        bus.wb_valid = 1'b0; bus.alloc_valid = 1'b1; bus.cm_ready = 1'b1;
        #1 chk("sim_cm_tag", bus.cm_tag, 1);
        tick();
        bus.alloc_valid = 1'b0; bus.cm_ready = 1'b0;
        #1 chk("sim_count", bus.count, 3);

        // asynchronous clear with a committable head
        wb(2, 32'hC2, 1'b0, 0);
        tick();
        bus.wb_valid = 1'b0; bus.cm_ready = 1'b1;
        #1 chk("pre_clr_cm_valid", bus.cm_valid, 1);
        clr = 1'b1;
        #1;
        chk("clr_count", bus.count, 0);
        chk("clr_cm_valid", bus.cm_valid, 0);
        chk("clr_alloc_ready", bus.alloc_ready, 0);
        tick();
        clr = 1'b0;
        #1;
        chk("post_clr_count", bus.count, 0);
        chk("post_clr_cm_valid", bus.cm_valid, 0);
        chk("post_clr_alloc_tag", bus.alloc_tag, 0);
        bus.cm_ready = 1'b0;

        // out-of-order writeback, in-order commit
        exp_v[0] = 32'h00; exp_v[1] = 32'h11; exp_v[2] = 32'h22;
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_kind = KIND_REG; bus.alloc_rd = 5'(i + 1);
            #1 chk("ooo_alloc_tag", bus.alloc_tag, 64'(i));
            tick();
        end
        bus.alloc_valid = 1'b0;
        wb(2, 32'h22, 1'b0, 0);
        #1 chk("ooo_wb2_cm_valid", bus.cm_valid, 0);
        tick();
        wb(0, 32'h00, 1'b0, 0);
        #1 chk("wb_latency_cm_valid", bus.cm_valid, 64'(BYP));
        tick();
        #1 chk("ooo_head_done", bus.cm_valid, 1);
        wb(1, 32'h11, 1'b0, 0);
        tick();
        bus.wb_valid = 1'b0; bus.cm_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ooo_cm_tag", bus.cm_tag, 64'(i));
            chk("ooo_cm_value", bus.cm_value, 64'(exp_v[i]));
            chk("ooo_cm_rd", bus.cm_rd, 64'(i + 1));
            tick();
        end
        #1;
        chk("ooo_drained_valid", bus.cm_valid, 0);
        chk("ooo_drained_count", bus.count, 0);
        bus.cm_ready = 1'b0;

        // ignored writebacks: outside the window, and to an already done entry
        bus.alloc_valid = 1'b1;
        #1 chk("ign_alloc_tag", bus.alloc_tag, 3);
        tick();
        bus.alloc_valid = 1'b0;
        wb(0, 32'h99, 1'b0, 0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk("ign_out_cm_valid", bus.cm_valid, 0);
        chk("ign_out_count", bus.count, 1);
        wb(3, 32'h33, 1'b0, 0);
        tick();
        wb(3, 32'h44, 1'b0, 0);
        tick();
        bus.wb_valid = 1'b0; bus.cm_ready = 1'b1;
        #1 chk("ign_done_value", bus.cm_value, 32'h33);
        tick();
        bus.cm_ready = 1'b0;
        #1 chk("ign_count", bus.count, 0);

        // redirect commit flushes younger entries
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid = 1'b1; bus.alloc_kind = (i == 0) ? KIND_BRANCH : KIND_REG; bus.alloc_rd = 5'(i + 1);
            #1 chk("fl_alloc_tag", bus.alloc_tag, 64'(i));
            tick();
        end
        bus.alloc_valid = 1'b0; bus.alloc_kind = KIND_REG;
        wb(0, 32'h0, 1'b1, 32'h1000);
        tick();
        wb(1, 32'h11, 1'b0, 0);
        tick();
        wb(2, 32'h22, 1'b0, 0);
        bus.alloc_valid = 1'b1; bus.cm_ready = 1'b1;
        #1;
        chk("fl_cm_valid", bus.cm_valid, 1);
        chk("fl_cm_kind", bus.cm_kind, 64'(KIND_BRANCH));
        chk("fl_cm_tag", bus.cm_tag, 0);
        tick();
        bus.alloc_valid = 1'b0; bus.wb_valid = 1'b0;
        #1;
        chk("fl_flush", bus.flush, 1);
        chk("fl_flush_pc", bus.flush_pc, 32'h1000);
        chk("fl_count", bus.count, 0);
        chk("fl_cm_valid_in_flush", bus.cm_valid, 0);
        chk("fl_alloc_ready", bus.alloc_ready, 0);
        tick();
        #1;
        chk("fl_flush_one_cycle", bus.flush, 0);
        chk("fl_no_younger_commit", bus.cm_valid, 0);
        chk("fl_count_after", bus.count, 0);

        // writeback-to-head latency, value 0x5A
        bus.alloc_valid = 1'b1;
        #1 chk("byp_alloc_tag", bus.alloc_tag, 1);
        tick();
        bus.alloc_valid = 1'b0;
        wb(1, 32'h5A, 1'b0, 0);
        bus.cm_ready = 1'b1;
        #1;
        chk("byp_same_cycle_valid", bus.cm_valid, 64'(BYP));
        if (BYP) begin
            chk("byp_same_cycle_value", bus.cm_value, 32'h5A);
            tick();
            bus.wb_valid = 1'b0;
            #1;
            chk("byp_count", bus.count, 0);
            chk("byp_cm_valid_after", bus.cm_valid, 0);
        end else begin
            tick();
            bus.wb_valid = 1'b0;
            #1;
            chk("nobyp_next_valid", bus.cm_valid, 1);
            chk("nobyp_next_value", bus.cm_value, 32'h5A);
            tick();
            #1 chk("nobyp_count", bus.count, 0);
        end
        bus.cm_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
